// File: rtl/mac_result_collector.sv
// mac_result_collector: captures the final running sum of each dot product
// from the MAC accumulator stream and queues it in a tagged FWFT FIFO.
//
// Optional feature: define MAC_COLLECT_RELU_EN to zero any pushed value
// whose sign bit is set (ReLU on the raw IEEE-754 bit pattern).
//
// Ports:
//   clock, areset       single clock, async active-high reset
//   vec_len             beats per vector, sampled on first beat (0 => 1)
//   acc_valid, acc_data accumulator running-sum beat
//   res_valid/ready     FIFO head handshake toward the next layer
//   res_data, res_tag   head result and its vector sequence number
//   overflow, clr_ovf   sticky drop flag and its synchronous clear
//   busy                a vector is partially received
module mac_result_collector #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             areset,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             acc_valid,
    input  logic [31:0]      acc_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [7:0]       res_tag,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] eff_len;
    logic [7:0]       tag_q;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             ovf_q;

    logic [31:0] data_mem [DEPTH];
    logic [7:0]  tag_mem  [DEPTH];

    logic        first;
    logic        last;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        drop;
    logic [31:0] push_data;

    // The first beat uses the live vec_len so a length-1 vector completes
    // on that same beat; later beats compare against the latched length.
    always_comb begin
        first   = (cnt == '0);
        eff_len = len_q;
        if (first) begin
            eff_len = (vec_len == '0) ? LEN_ONE : vec_len;
        end
        last = acc_valid && (cnt == (eff_len - LEN_ONE));
    end

`ifdef MAC_COLLECT_RELU_EN
    assign push_data = acc_data[31] ? 32'h0000_0000 : acc_data;
`else
    assign push_data = acc_data;
`endif

    // Full: same slot, opposite lap. Empty: identical pointers.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop  = !empty && res_ready;
    assign push = last && (!full || pop);
    assign drop = last && full && !pop;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            cnt   <= '0;
            len_q <= LEN_ONE;
            tag_q <= 8'd0;
        end else if (acc_valid) begin
            if (first) begin
                len_q <= eff_len;
            end
            if (last) begin
                cnt   <= '0;
                tag_q <= tag_q + 8'd1;
            end else begin
                cnt <= cnt + LEN_ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the outputs are gated by the empty flag.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wptr[AW-1:0]] <= push_data;
            tag_mem[wptr[AW-1:0]]  <= tag_q;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign res_valid = !empty;
    assign res_data  = empty ? 32'h0000_0000 : data_mem[rptr[AW-1:0]];
    assign res_tag   = empty ? 8'd0 : tag_mem[rptr[AW-1:0]];
    assign overflow  = ovf_q;
    assign busy      = (cnt != '0);

endmodule
